// File: rtl/wb_slave_port_np_if.sv
// -----------------------------------------------------------------------------
// wb_slave_port_np_if
//   Bundle of the Wishbone signals that cross wb_slave_port_np: the N master
//   request/response vectors (master i at slice i) and the single slave side.
//   Signal suffixes (_i/_o) are as seen from the port module.
// Modports
//   slave  : view taken by wb_slave_port_np (serves the masters, drives the slave)
//   master : opposite view, for whatever drives the masters and models the slave
// -----------------------------------------------------------------------------
interface wb_slave_port_np_if #(
    parameter int NUM_MST = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BLW     = 10
);
    // master side
    logic [NUM_MST*DW-1:0]   m_wbd_dat_i;
    logic [NUM_MST*AW-1:0]   m_wbd_adr_i;
    logic [NUM_MST*DW/8-1:0] m_wbd_sel_i;
    logic [NUM_MST*BLW-1:0]  m_wbd_bl_i;
    logic [NUM_MST-1:0]      m_wbd_bry_i;
    logic [NUM_MST-1:0]      m_wbd_we_i;
    logic [NUM_MST-1:0]      m_wbd_cyc_i;
    logic [NUM_MST-1:0]      m_wbd_stb_i;
    logic [NUM_MST*4-1:0]    m_wbd_tid_i;
    logic [NUM_MST*DW-1:0]   m_wbd_dat_o;
    logic [NUM_MST-1:0]      m_wbd_ack_o;
    logic [NUM_MST-1:0]      m_wbd_lack_o;
    logic [NUM_MST-1:0]      m_wbd_err_o;
    // slave side
    logic [DW-1:0]           s_wbd_dat_i;
    logic                    s_wbd_ack_i;
    logic                    s_wbd_lack_i;
    logic [DW-1:0]           s_wbd_dat_o;
    logic [AW-1:0]           s_wbd_adr_o;
    logic [DW/8-1:0]         s_wbd_sel_o;
    logic [BLW-1:0]          s_wbd_bl_o;
    logic                    s_wbd_bry_o;
    logic                    s_wbd_we_o;
    logic                    s_wbd_cyc_o;
    logic                    s_wbd_stb_o;

    modport slave (
        input  m_wbd_dat_i, m_wbd_adr_i, m_wbd_sel_i, m_wbd_bl_i, m_wbd_bry_i,
               m_wbd_we_i, m_wbd_cyc_i, m_wbd_stb_i, m_wbd_tid_i,
               s_wbd_dat_i, s_wbd_ack_i, s_wbd_lack_i,
        output m_wbd_dat_o, m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o,
               s_wbd_dat_o, s_wbd_adr_o, s_wbd_sel_o, s_wbd_bl_o, s_wbd_bry_o,
               s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o
    );

    modport master (
        output m_wbd_dat_i, m_wbd_adr_i, m_wbd_sel_i, m_wbd_bl_i, m_wbd_bry_i,
               m_wbd_we_i, m_wbd_cyc_i, m_wbd_stb_i, m_wbd_tid_i,
               s_wbd_dat_i, s_wbd_ack_i, s_wbd_lack_i,
        input  m_wbd_dat_o, m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o,
               s_wbd_dat_o, s_wbd_adr_o, s_wbd_sel_o, s_wbd_bl_o, s_wbd_bry_o,
               s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o
    );
endinterface

// File: rtl/wb_slave_port_np.sv
// -----------------------------------------------------------------------------
// wb_slave_port_np
//   N-master to 1-slave Wishbone port. Masters addressing this slave (by target
//   id) are served one at a time under round-robin arbitration. The owner keeps
//   the slave until last-ack, abort (strobe dropped) or watchdog timeout.
// Ports
//   clk_i         clock
//   rst_n         synchronous active-low reset
//   cfg_slave_id  target id of this slave
//   cfg_tmo_en    enables the silent-slave watchdog
//   bus           wb_slave_port_np_if.slave: master vectors + slave signals
//   gnt_id_o      current owner index (BUSY/DONE), 0 otherwise
//   tmo_evt_o     one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_slave_port_np #(
    parameter int NUM_MST = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int BLW     = 10,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [3:0]          cfg_slave_id,
    input  logic                cfg_tmo_en,
    wb_slave_port_np_if.slave   bus,
    output logic [2:0]          gnt_id_o,
    output logic                tmo_evt_o
);
    localparam int SW   = DW / 8;
    localparam int MAXM = 8;    // per-master tables padded so a 3-bit index is exact

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic [TMO_W-1:0] tmo_cnt_q;

    logic [DW-1:0]    dat_a [MAXM];
    logic [AW-1:0]    adr_a [MAXM];
    logic [SW-1:0]    sel_a [MAXM];
    logic [BLW-1:0]   bl_a  [MAXM];
    logic [MAXM-1:0]  req, cyc_a, we_a, bry_a;

    logic             busy, done_st, g_req, s_any_ack, tmo_hit, any_req, found;
    logic [2:0]       pick;
    int               rr_idx;

    // Slice the flat master vectors into indexable tables.
    for (genvar i = 0; i < MAXM; i++) begin : g_slice
        if (i < NUM_MST) begin : g_real
            logic unused_lsb;
            // Word-aligned slave: address bits [1:0] are dropped on purpose.
            assign unused_lsb = ^bus.m_wbd_adr_i[i*AW +: 2];
            assign dat_a[i] = bus.m_wbd_dat_i[i*DW +: DW];
            assign adr_a[i] = {bus.m_wbd_adr_i[i*AW+2 +: AW-2], 2'b00};
            assign sel_a[i] = bus.m_wbd_sel_i[i*SW +: SW];
            assign bl_a[i]  = bus.m_wbd_bl_i[i*BLW +: BLW];
            assign cyc_a[i] = bus.m_wbd_cyc_i[i];
            assign we_a[i]  = bus.m_wbd_we_i[i];
            assign bry_a[i] = bus.m_wbd_bry_i[i];
            assign req[i]   = bus.m_wbd_stb_i[i] & (bus.m_wbd_tid_i[i*4 +: 4] == cfg_slave_id);
        end else begin : g_pad
            assign dat_a[i] = '0;
            assign adr_a[i] = '0;
            assign sel_a[i] = '0;
            assign bl_a[i]  = '0;
            assign cyc_a[i] = 1'b0;
            assign we_a[i]  = 1'b0;
            assign bry_a[i] = 1'b0;
            assign req[i]   = 1'b0;
        end
    end

    // Outputs are gated by rst_n so they read 0 during the reset cycle itself.
    assign busy      = rst_n && (state_q == BUSY);
    assign done_st   = rst_n && (state_q == DONE);
    assign g_req     = req[gnt_q];
    assign s_any_ack = bus.s_wbd_ack_i | bus.s_wbd_lack_i;
    // Any slave ack in the same cycle beats the watchdog.
    assign tmo_hit   = busy && g_req && cfg_tmo_en && !s_any_ack &&
                       (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    assign any_req   = |req;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick   = last_gnt_q;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = 1; k <= NUM_MST; k++) begin
            rr_idx = int'(last_gnt_q) + k;
            if (rr_idx >= NUM_MST) rr_idx = rr_idx - NUM_MST;
            if (!found && req[3'(rr_idx)]) begin
                found = 1'b1;
                pick  = 3'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: if (any_req) begin
                state_d    = BUSY;
                gnt_d      = pick;
                last_gnt_d = pick;
            end
            BUSY: if (bus.s_wbd_lack_i || tmo_hit || !g_req) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous (sampled on the clock edge), not in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= 3'(NUM_MST - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Watchdog: held at 0 outside BUSY (so it is clear on entry), cleared by
    // any slave ack, counts stalled strobe cycles and saturates.
    always_ff @(posedge clk_i) begin
        if (!rst_n || state_q != BUSY) begin
            tmo_cnt_q <= '0;
        end else if (s_any_ack) begin
            tmo_cnt_q <= '0;
        end else if (g_req && tmo_cnt_q != '1) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.m_wbd_dat_o  = '0;
        bus.m_wbd_ack_o  = '0;
        bus.m_wbd_lack_o = '0;
        bus.m_wbd_err_o  = '0;
        // Responses reach only the owner, and only while it still strobes.
        for (int i = 0; i < NUM_MST; i++) begin
            if (busy && g_req && gnt_q == 3'(i)) begin
                bus.m_wbd_dat_o[i*DW +: DW] = bus.s_wbd_dat_i;
                bus.m_wbd_ack_o[i]          = bus.s_wbd_ack_i;
                bus.m_wbd_lack_o[i]         = bus.s_wbd_lack_i | tmo_hit;
                bus.m_wbd_err_o[i]          = tmo_hit;
            end
        end
        bus.s_wbd_dat_o = busy ? dat_a[gnt_q] : '0;
        bus.s_wbd_adr_o = busy ? adr_a[gnt_q] : '0;
        bus.s_wbd_sel_o = busy ? sel_a[gnt_q] : '0;
        bus.s_wbd_bl_o  = busy ? bl_a[gnt_q]  : '0;
        bus.s_wbd_bry_o = busy && bry_a[gnt_q];
        bus.s_wbd_we_o  = busy && we_a[gnt_q];
        bus.s_wbd_cyc_o = busy && cyc_a[gnt_q];
        bus.s_wbd_stb_o = busy && g_req && !tmo_hit;
    end

    assign gnt_id_o  = (busy || done_st) ? gnt_q : 3'd0;
    assign tmo_evt_o = tmo_hit;

endmodule

// File: tb/tb_wb_slave_port_np.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_port_np
//   Directed + randomized bench for wb_slave_port_np (4 masters, TMO_CYC=16).
//   Expected grants come from a round-robin pointer model; expected bus values
//   come from the bench's own copy of each master's request fields.
// -----------------------------------------------------------------------------
module tb_wb_slave_port_np;
    localparam int NM  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BLW = 10;
    localparam int TW  = 8;
    localparam int TC  = 16;
    localparam logic [3:0] SID = 4'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cfg_slave_id = SID;
    logic       cfg_tmo_en = 1'b1;
    logic [2:0] gnt_id;
    logic       tmo_evt;

    int n_checks = 0;
    int n_err = 0;
    int rr_ptr = NM - 1;

    wb_slave_port_np_if #(.NUM_MST(NM), .DW(DW), .AW(AW), .BLW(BLW)) bus ();

    wb_slave_port_np #(
        .NUM_MST(NM), .DW(DW), .AW(AW), .BLW(BLW), .TMO_W(TW), .TMO_CYC(TC)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .cfg_slave_id(cfg_slave_id), .cfg_tmo_en(cfg_tmo_en),
        .bus(bus), .gnt_id_o(gnt_id), .tmo_evt_o(tmo_evt)
    );

    always #5 clk = ~clk;

    // bench copy of every master's request
    logic [DW-1:0]   md   [NM];
    logic [AW-1:0]   ma   [NM];
    logic [DW/8-1:0] msel [NM];
    logic [BLW-1:0]  mbl  [NM];
    logic            mbry [NM];
    logic            mwe  [NM];
    logic            mcyc [NM];
    logic            mstb [NM];
    logic [3:0]      mtid [NM];

    task automatic check(input string tag, input logic [NM*DW-1:0] obs, input logic [NM*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            bus.m_wbd_dat_i[i*DW +: DW]     = md[i];
            bus.m_wbd_adr_i[i*AW +: AW]     = ma[i];
            bus.m_wbd_sel_i[i*DW/8 +: DW/8] = msel[i];
            bus.m_wbd_bl_i[i*BLW +: BLW]    = mbl[i];
            bus.m_wbd_bry_i[i]              = mbry[i];
            bus.m_wbd_we_i[i]               = mwe[i];
            bus.m_wbd_cyc_i[i]              = mcyc[i];
            bus.m_wbd_stb_i[i]              = mstb[i];
            bus.m_wbd_tid_i[i*4 +: 4]       = mtid[i];
        end
    endtask

    task automatic set_master(input int i, input logic on, input logic [3:0] tid);
        md[i]   = $urandom;
        ma[i]   = $urandom;
        msel[i] = 4'($urandom);
        mbl[i]  = BLW'($urandom_range(1, 16));
        mbry[i] = 1'($urandom);
        mwe[i]  = 1'($urandom);
        mcyc[i] = on;
        mstb[i] = on;
        mtid[i] = tid;
        drive();
    endtask

    // A master requests this slave when it strobes with the matching target id.
    function automatic logic [NM-1:0] req_mask();
        logic [NM-1:0] m;
        for (int i = 0; i < NM; i++) m[i] = mstb[i] && (mtid[i] == SID);
        return m;
    endfunction

    // First requester after ptr, wrapping around; -1 when nobody asks.
    function automatic int rr_pick(input int ptr, input logic [NM-1:0] m);
        for (int k = 1; k <= NM; k++) begin
            if (m[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    // Owner o holds the slave: request fields are o's, response goes only to o.
    task automatic chk_busy(input string tag, input int o, input logic stb, input logic ack,
                            input logic lack, input logic err, input logic evt);
        logic [NM-1:0]    oh;
        logic [NM-1:0]    rq;
        logic [NM*DW-1:0] edat;
        oh   = NM'(1) << o;
        rq   = req_mask();
        edat = '0;
        if (rq[o]) edat[o*DW +: DW] = bus.s_wbd_dat_i;
        check({tag, ":gnt"},    gnt_id, o);
        check({tag, ":s_cyc"},  bus.s_wbd_cyc_o, mcyc[o]);
        check({tag, ":s_stb"},  bus.s_wbd_stb_o, stb);
        check({tag, ":s_adr"},  bus.s_wbd_adr_o, {ma[o][AW-1:2], 2'b00});
        check({tag, ":s_dat"},  bus.s_wbd_dat_o, md[o]);
        check({tag, ":s_sel"},  bus.s_wbd_sel_o, msel[o]);
        check({tag, ":s_bl"},   bus.s_wbd_bl_o, mbl[o]);
        check({tag, ":s_bry"},  bus.s_wbd_bry_o, mbry[o]);
        check({tag, ":s_we"},   bus.s_wbd_we_o, mwe[o]);
        check({tag, ":m_ack"},  bus.m_wbd_ack_o, ack ? oh : '0);
        check({tag, ":m_lack"}, bus.m_wbd_lack_o, lack ? oh : '0);
        check({tag, ":m_err"},  bus.m_wbd_err_o, err ? oh : '0);
        check({tag, ":m_dat"},  bus.m_wbd_dat_o, edat);
        check({tag, ":tmo_evt"}, tmo_evt, evt);
    endtask

    // Slave quiet, no responses; full also requires every request field at 0.
    task automatic chk_quiet(input string tag, input int g, input logic full);
        check({tag, ":gnt"},    gnt_id, g);
        check({tag, ":s_cyc"},  bus.s_wbd_cyc_o, 0);
        check({tag, ":s_stb"},  bus.s_wbd_stb_o, 0);
        check({tag, ":m_ack"},  bus.m_wbd_ack_o, 0);
        check({tag, ":m_lack"}, bus.m_wbd_lack_o, 0);
        check({tag, ":m_err"},  bus.m_wbd_err_o, 0);
        check({tag, ":tmo_evt"}, tmo_evt, 0);
        if (full) begin
            check({tag, ":s_dat"}, bus.s_wbd_dat_o, 0);
            check({tag, ":s_adr"}, bus.s_wbd_adr_o, 0);
            check({tag, ":s_sel"}, bus.s_wbd_sel_o, 0);
            check({tag, ":s_bl"},  bus.s_wbd_bl_o, 0);
            check({tag, ":s_bry"}, bus.s_wbd_bry_o, 0);
            check({tag, ":s_we"},  bus.s_wbd_we_o, 0);
            check({tag, ":m_dat"}, bus.m_wbd_dat_o, 0);
        end
    endtask

    // Starts in IDLE with requests applied; ends back in IDLE after DONE.
    task automatic do_txn(input string tag, input int nbeats, input int max_wait,
                          input logic [NM-1:0] late, output int o);
        logic [NM-1:0] m;
        m = req_mask();
        @(negedge clk);
        chk_quiet({tag, "_idle"}, 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        tick();
        if (o < 0) return;
        rr_ptr = o;
        for (int i = 0; i < NM; i++) if (late[i]) set_master(i, 1'b1, SID);
        for (int b = 0; b < nbeats; b++) begin
            md[o] = $urandom;
            drive();
            repeat ($urandom_range(0, max_wait)) begin
                @(negedge clk);
                chk_busy({tag, "_wait"}, o, 1, 0, 0, 0, 0);
                tick();
            end
            bus.s_wbd_dat_i  = $urandom;
            bus.s_wbd_ack_i  = 1'b1;
            bus.s_wbd_lack_i = (b == nbeats - 1);
            @(negedge clk);
            chk_busy({tag, "_beat"}, o, 1, 1, b == nbeats - 1, 0, 0);
            tick();
            bus.s_wbd_ack_i  = 1'b0;
            bus.s_wbd_lack_i = 1'b0;
        end
        @(negedge clk);
        chk_quiet({tag, "_done"}, o, 1'b0);
        tick();
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) set_master(i, 1'b0, SID);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int o;
        logic [NM-1:0] m;
        bus.s_wbd_dat_i  = '0;
        bus.s_wbd_ack_i  = 1'b0;
        bus.s_wbd_lack_i = 1'b0;
        idle_all();

        // reset state
        repeat (2) tick();
        @(negedge clk);
        chk_quiet("reset", 0, 1'b1);
        tick();
        rst_n = 1'b1;

        // 1: masters 0 and 2 request continuously -> alternate
        set_master(0, 1'b1, SID);
        set_master(2, 1'b1, SID);
        for (int t = 0; t < 4; t++) do_txn("t1", 1, 2, '0, o);

        // 2: master 1 burst of 4; 0 and 3 arrive mid-burst and wait
        idle_all();
        set_master(1, 1'b1, SID);
        mbl[1] = 10'd4;
        mwe[1] = 1'b0;
        drive();
        do_txn("t2", 4, 2, 4'b1001, o);
        set_master(1, 1'b0, SID);
        do_txn("t2_next", 1, 1, '0, o);
        do_txn("t2_next", 1, 1, '0, o);

        // 3: silent slave with watchdog, then next requester served
        idle_all();
        set_master(0, 1'b1, SID);
        set_master(1, 1'b1, SID);
        cfg_tmo_en = 1'b1;
        m = req_mask();
        @(negedge clk);
        chk_quiet("t3_idle", 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        rr_ptr = o;
        tick();
        for (int c = 0; c < TC; c++) begin
            @(negedge clk);
            if (c < TC - 1) chk_busy("t3_wait", o, 1, 0, 0, 0, 0);
            else            chk_busy("t3_tmo", o, 0, 0, 1, 1, 1);
            tick();
        end
        @(negedge clk);
        chk_quiet("t3_done", o, 1'b0);
        set_master(o, 1'b0, SID);
        tick();
        do_txn("t3_next", 1, 1, '0, o);

        // 3b: ack on the would-be timeout cycle wins and restarts the count
        m = req_mask();
        @(negedge clk);
        chk_quiet("t3b_idle", 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        rr_ptr = o;
        tick();
        for (int c = 0; c < TC - 1; c++) begin
            @(negedge clk);
            chk_busy("t3b_wait", o, 1, 0, 0, 0, 0);
            tick();
        end
        bus.s_wbd_ack_i = 1'b1;
        @(negedge clk);
        chk_busy("t3b_ackwins", o, 1, 1, 0, 0, 0);
        tick();
        bus.s_wbd_ack_i = 1'b0;
        for (int c = 0; c < TC - 1; c++) begin
            @(negedge clk);
            chk_busy("t3b_rewait", o, 1, 0, 0, 0, 0);
            tick();
        end
        bus.s_wbd_ack_i  = 1'b1;
        bus.s_wbd_lack_i = 1'b1;
        @(negedge clk);
        chk_busy("t3b_last", o, 1, 1, 1, 0, 0);
        tick();
        bus.s_wbd_ack_i  = 1'b0;
        bus.s_wbd_lack_i = 1'b0;
        @(negedge clk);
        chk_quiet("t3b_done", o, 1'b0);
        tick();

        // 4: watchdog off holds BUSY; counter saturates so enabling later never fires
        idle_all();
        set_master(3, 1'b1, SID);
        cfg_tmo_en = 1'b0;
        m = req_mask();
        @(negedge clk);
        chk_quiet("t4_idle", 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        rr_ptr = o;
        tick();
        for (int c = 0; c < 560; c++) begin
            if (c == 300) cfg_tmo_en = 1'b1;
            @(negedge clk);
            chk_busy("t4_hold", o, 1, 0, 0, 0, 0);
            tick();
        end
        bus.s_wbd_ack_i  = 1'b1;
        bus.s_wbd_lack_i = 1'b1;
        @(negedge clk);
        chk_busy("t4_last", o, 1, 1, 1, 0, 0);
        tick();
        bus.s_wbd_ack_i  = 1'b0;
        bus.s_wbd_lack_i = 1'b0;
        set_master(3, 1'b0, SID);
        @(negedge clk);
        chk_quiet("t4_done", o, 1'b0);
        tick();

        // 5: wrong target id never wins
        set_master(1, 1'b1, 4'd5);
        repeat (6) begin
            @(negedge clk);
            chk_quiet("t5_tid", 0, 1'b1);
            tick();
        end

        // abort: owner drops stb while slave acks -> nothing forwarded
        idle_all();
        set_master(2, 1'b1, SID);
        m = req_mask();
        @(negedge clk);
        chk_quiet("ab_idle", 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        rr_ptr = o;
        tick();
        @(negedge clk);
        chk_busy("ab_busy", o, 1, 0, 0, 0, 0);
        tick();
        mstb[o] = 1'b0;
        drive();
        bus.s_wbd_ack_i = 1'b1;
        bus.s_wbd_dat_i = $urandom;
        @(negedge clk);
        chk_busy("ab_drop", o, 0, 0, 0, 0, 0);
        tick();
        bus.s_wbd_ack_i = 1'b0;
        @(negedge clk);
        chk_quiet("ab_done", o, 1'b0);
        tick();

        // random traffic
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NM; i++)
                set_master(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0) ? 4'd5 : SID);
            do_txn("rnd", $urandom_range(1, 4), 3, '0, o);
        end

        // 6: reset during the 3rd beat of a burst
        idle_all();
        set_master(1, 1'b1, SID);
        mbl[1] = 10'd4;
        drive();
        m = req_mask();
        @(negedge clk);
        chk_quiet("t6_idle", 0, 1'b1);
        o = rr_pick(rr_ptr, m);
        rr_ptr = o;
        tick();
        for (int b = 0; b < 2; b++) begin
            bus.s_wbd_dat_i = $urandom;
            bus.s_wbd_ack_i = 1'b1;
            @(negedge clk);
            chk_busy("t6_beat", o, 1, 1, 0, 0, 0);
            tick();
            bus.s_wbd_ack_i = 1'b0;
        end
        rst_n = 1'b0;
        bus.s_wbd_ack_i = 1'b1;
        set_master(3, 1'b1, SID);
        @(negedge clk);
        chk_quiet("t6_in_rst", 0, 1'b1);
        tick();
        rst_n = 1'b1;
        bus.s_wbd_ack_i = 1'b0;
        rr_ptr = NM - 1;
        do_txn("t6_post", 2, 1, '0, o);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
